m_cp0_ext: RTL and testbench

- Parametrised successor to the pipeline's coprocessor-0 unit; sits in the MEM stage of the five-stage flow CPU.
- Arbitrates hardware interrupts and synchronous exceptions and raises the pipeline-wide Req flush.
- Holds SR, Cause, EPC, PRId and a new Count/Compare timer.
- Generalised over interrupt-line count, with an optional internal timer interrupt and an EPC bypass for eret.

---
 rtl/m_cp0_ext_if.sv | 28 ++
 rtl/m_cp0_ext.sv | 115 +++++++++++
 tb/tb_m_cp0_ext.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/m_cp0_ext_if.sv
// MEM-stage pipeline <-> coprocessor-0 signal bundle.
// The pipeline side is the master; the CP0 unit is the slave.
interface m_cp0_ext_if #(
  parameter int NUM_HWINT = 6
);
  logic                 en;
  logic [4:0]           CP0Add;
  logic [31:0]          CP0In;
  logic [31:0]          CP0Out;
  logic [31:0]          VPC;
  logic                 BDIn;
  logic [4:0]           ExcCodeIn;
  logic [NUM_HWINT-1:0] HWInt;
  logic                 EXLClr;
  logic [31:0]          EPCOut;
  logic [31:0]          ExcPC;
  logic                 Req;
  logic                 TimerIrq;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, ExcPC, Req, TimerIrq
  );
  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, ExcPC, Req, TimerIrq
  );
endinterface

// File: rtl/m_cp0_ext.sv
// Coprocessor 0 for the MEM stage: interrupt/exception arbitration, SR/Cause/EPC/PRId
// and a Count/Compare timer whose match can drive the top interrupt line.
module m_cp0_ext #(
  parameter int          NUM_HWINT = 6,
  parameter bit          TIMER_EN  = 1'b1,
  parameter logic [31:0] PRID_VAL  = 32'h2022_0701,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input logic        clk,
  input logic        reset,
  m_cp0_ext_if.slave bus
);
  localparam int IPH = 10 + NUM_HWINT - 1;

  logic                 sr_ie, sr_exl;
  logic [NUM_HWINT-1:0] sr_im;
  logic                 cause_bd;
  logic [NUM_HWINT-1:0] cause_ip;
  logic [4:0]           cause_exc;
  logic [31:0]          epc, count, compare;
  logic                 timer_irq;

  logic [NUM_HWINT-1:0] tmr_line, ip_eff;
  logic                 int_req, exc_req, req;
  logic                 wr_sr, wr_epc, wr_count, wr_compare, cnt_match;
  logic [31:0]          epc_raw, rd;

  // Timer flag only reaches the highest line; IP is the live vector, not Cause.IP.
  always_comb begin
    tmr_line                = '0;
    tmr_line[NUM_HWINT-1]   = TIMER_EN & timer_irq;
    ip_eff                  = bus.HWInt | tmr_line;
  end

  assign int_req = sr_ie & ~sr_exl & (|(ip_eff & sr_im));
  assign exc_req = ~sr_exl & (bus.ExcCodeIn != 5'd0);
  assign req     = int_req | exc_req;

  assign wr_sr      = bus.en & ~req & (bus.CP0Add == 5'd12);
  assign wr_epc     = bus.en & ~req & (bus.CP0Add == 5'd14);
  assign wr_count   = bus.en & ~req & (bus.CP0Add == 5'd9);
  assign wr_compare = bus.en & ~req & (bus.CP0Add == 5'd11);
  assign cnt_match  = TIMER_EN && (compare != 32'd0) && (count == compare);

  assign epc_raw = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;

  always_comb begin
    rd = '0;
    case (bus.CP0Add)
      5'd9:  rd = count;
      5'd11: rd = compare;
      5'd12: begin
        rd[IPH:10] = sr_im;
        rd[1]      = sr_exl;
        rd[0]      = sr_ie;
      end
      5'd13: begin
        rd[31]     = cause_bd;
        rd[30]     = timer_irq;
        rd[IPH:10] = cause_ip;
        rd[6:2]    = cause_exc;
      end
      5'd14: rd = epc;
      5'd15: rd = PRID_VAL;
      default: rd = '0;
    endcase
  end

  assign bus.CP0Out   = rd;
  assign bus.Req      = req;
  assign bus.ExcPC    = EXC_VEC;
  assign bus.TimerIrq = timer_irq;
  // Lets an eret directly behind an mtc0 EPC pick up the new value.
  assign bus.EPCOut   = wr_epc ? {bus.CP0In[31:2], 2'b00} : epc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_ie     <= 1'b0;
      sr_exl    <= 1'b0;
      sr_im     <= '0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
      count     <= '0;
      compare   <= '0;
      timer_irq <= 1'b0;
    end else begin
      cause_ip <= ip_eff;
      count    <= wr_count ? bus.CP0In : count + 32'd1;

      if (wr_compare) begin
        compare   <= bus.CP0In;
        timer_irq <= 1'b0;
      end else if (cnt_match) begin
        timer_irq <= 1'b1;
      end

      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'd0 : bus.ExcCodeIn;
        cause_bd  <= bus.BDIn;
        epc       <= {epc_raw[31:2], 2'b00};
      end else begin
        if (wr_sr) begin
          sr_ie  <= bus.CP0In[0];
          sr_exl <= bus.CP0In[1];
          sr_im  <= bus.CP0In[IPH:10];
        end
        if (bus.EXLClr) sr_exl <= 1'b0;
        if (wr_epc) epc <= {bus.CP0In[31:2], 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_m_cp0_ext.sv
// Scoreboard bench for m_cp0_ext: directed scenarios then random traffic, checked
// against a word-level model of the CP0 register rules.
module tb_m_cp0_ext;
  localparam int          N      = 6;
  localparam logic [31:0] PRID   = 32'h2022_0701;
  localparam logic [31:0] EVEC   = 32'h0000_4180;
  localparam logic [31:0] IMASK  = 32'h3F;
  localparam logic [31:0] SRMASK = 32'h0000_FC03;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  m_cp0_ext_if #(.NUM_HWINT(N)) bus ();
  m_cp0_ext #(.NUM_HWINT(N), .TIMER_EN(1'b1), .PRID_VAL(PRID), .EXC_VEC(EVEC))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic en; logic [4:0] add; logic [31:0] din; logic [31:0] vpc;
    logic bd; logic [4:0] code; logic [N-1:0] hw; logic clr;
  } stim_t;

  // kind: 0 none, 1 CP0Out constant, 2 EPCOut constant, 3 Req constant
  typedef struct {
    logic req; logic [31:0] rd; logic [31:0] epco; logic ti;
    int kind; logic [31:0] k;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // Reference state, held as plain architectural words.
  logic [31:0] m_sr, m_epc, m_cnt, m_cmp, m_cip;
  logic        m_bd, m_ti;
  logic [4:0]  m_exc;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.en = 0; s.add = 0; s.din = 0; s.vpc = 0; s.bd = 0; s.code = 0; s.hw = '0; s.clr = 0;
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:  return m_cnt;
      5'd11: return m_cmp;
      5'd12: return m_sr;
      5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (m_cip << 10) | (32'(m_exc) << 2);
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_sr = 0; m_epc = 0; m_cnt = 0; m_cmp = 0; m_cip = 0; m_bd = 0; m_ti = 0; m_exc = 0;
  endtask

  task automatic go(input stim_t s, input int kind = 0, input logic [31:0] k = 0);
    exp_t e;
    logic [31:0] ip, im;
    logic intr, excr, req, match, wr;
    @(negedge clk);
    reset = 1'b1;
    bus.en = s.en; bus.CP0Add = s.add; bus.CP0In = s.din; bus.VPC = s.vpc;
    bus.BDIn = s.bd; bus.ExcCodeIn = s.code; bus.HWInt = s.hw; bus.EXLClr = s.clr;

    ip   = 32'(s.hw) | (m_ti ? 32'h20 : 32'h0);
    im   = (m_sr >> 10) & IMASK;
    intr = m_sr[0] && !m_sr[1] && ((ip & im) != 0);
    excr = !m_sr[1] && (s.code != 0);
    req  = intr || excr;
    wr   = s.en && !req;

    e.req  = req;
    e.rd   = m_read(s.add);
    e.epco = (wr && s.add == 14) ? (s.din & ~32'd3) : m_epc;
    e.ti   = m_ti;
    e.kind = kind;
    e.k    = k;
    q.push_back(e);

    match = (m_cmp != 0) && (m_cnt == m_cmp);
    m_cnt = (wr && s.add == 9) ? s.din : m_cnt + 1;
    if (wr && s.add == 11) begin m_cmp = s.din; m_ti = 0; end
    else if (match) m_ti = 1;
    m_cip = ip;
    if (req) begin
      m_sr  = m_sr | 32'd2;
      m_exc = intr ? 5'd0 : s.code;
      m_bd  = s.bd;
      m_epc = (s.bd ? s.vpc - 4 : s.vpc) & ~32'd3;
    end else begin
      if (wr && s.add == 12) m_sr = s.din & SRMASK;
      if (s.clr) m_sr = m_sr & ~32'd2;
      if (wr && s.add == 14) m_epc = s.din & ~32'd3;
    end
    @(posedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b0;
    bus.en = 0; bus.EXLClr = 0; bus.ExcCodeIn = 0; bus.HWInt = '1;
    repeat (n) @(posedge clk);
    model_reset();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("req", 32'(bus.Req), 32'(e.req));
        chk("cp0out", bus.CP0Out, e.rd);
        chk("epcout", bus.EPCOut, e.epco);
        chk("timerirq", 32'(bus.TimerIrq), 32'(e.ti));
        chk("excpc", bus.ExcPC, EVEC);
        case (e.kind)
          1: chk("cp0out_const", bus.CP0Out, e.k);
          2: chk("epcout_const", bus.EPCOut, e.k);
          3: chk("req_const", 32'(bus.Req), e.k);
          default: ;
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    bus.en = 0; bus.CP0Add = 0; bus.CP0In = 0; bus.VPC = 0; bus.BDIn = 0;
    bus.ExcCodeIn = 0; bus.HWInt = '1; bus.EXLClr = 0;
    model_reset();

    // reset with all lines high
    do_reset(2);
    s = idle(); s.hw = '1; s.add = 9;  go(s, 1, 32'd0);
    s = idle(); s.hw = '1; s.add = 9;  go(s, 1, 32'd1);
    s = idle(); s.hw = '1; s.add = 12; go(s, 1, 32'd0);

    // exception outside a delay slot
    s = idle(); s.code = 12; s.vpc = 32'h3010; go(s, 3, 32'd1);
    s = idle(); s.code = 12; s.add = 14; go(s, 1, 32'h3010);
    s = idle(); s.code = 12; s.add = 13; go(s, 1, 32'h30);
    s = idle(); s.add = 12; go(s, 1, 32'd2);

    // interrupt in a delay slot beats an exception
    s = idle(); s.clr = 1; go(s);
    s = idle(); s.en = 1; s.add = 12; s.din = 32'h401; go(s);
    s = idle(); s.hw = 6'h01; s.code = 10; s.vpc = 32'h3020; s.bd = 1; go(s, 3, 32'd1);
    s = idle(); s.add = 14; go(s, 1, 32'h301C);
    s = idle(); s.add = 13; go(s, 1, 32'h8000_0000);

    // masking, eret, eret colliding with a request
    s = idle(); s.clr = 1; go(s);
    s = idle(); s.en = 1; s.add = 12; s.din = 32'h1; go(s);
    s = idle(); s.hw = '1; s.add = 12; go(s, 3, 32'd0);
    s = idle(); s.en = 1; s.add = 12; s.din = 32'h3; go(s);
    s = idle(); s.clr = 1; s.add = 12; go(s, 1, 32'h3);
    s = idle(); s.add = 12; go(s, 1, 32'h1);
    s = idle(); s.code = 4; s.clr = 1; s.vpc = 32'h3100; go(s, 3, 32'd1);
    s = idle(); s.add = 12; go(s, 1, 32'h3);
    s = idle(); s.add = 14; go(s, 1, 32'h3100);

    // EPC bypass and suppression of mtc0 under Req
    s = idle(); s.clr = 1; go(s);
    s = idle(); s.en = 1; s.add = 14; s.din = 32'h3047; go(s, 2, 32'h3044);
    s = idle(); s.add = 14; go(s, 1, 32'h3044);
    s = idle(); s.en = 1; s.add = 14; s.din = 32'h3047; s.code = 6; s.vpc = 32'h3200; go(s, 2, 32'h3044);
    s = idle(); s.add = 14; go(s, 1, 32'h3200);
    s = idle(); s.clr = 1; go(s);

    // timer interrupt on the top line
    s = idle(); s.en = 1; s.add = 12; s.din = 32'h8001; go(s);
    s = idle(); s.en = 1; s.add = 9;  s.din = 32'd0; go(s);
    s = idle(); s.en = 1; s.add = 11; s.din = 32'd5; go(s);
    repeat (5) begin s = idle(); s.add = 9; go(s); end
    s = idle(); go(s, 3, 32'd1);
    s = idle(); s.en = 1; s.add = 11; s.din = 32'd7; go(s);
    s = idle(); s.add = 13; go(s, 1, 32'h0000_8000);

    // Count wrap
    s = idle(); s.en = 1; s.add = 9; s.din = 32'hFFFF_FFFF; go(s);
    s = idle(); s.add = 9; go(s, 1, 32'hFFFF_FFFF);
    s = idle(); s.add = 9; go(s, 1, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] adds [8];
      adds = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};
      s = idle();
      s.en   = ($urandom_range(0, 2) == 0);
      s.add  = adds[$urandom_range(0, 7)];
      s.din  = $urandom;
      if ((s.add == 9 || s.add == 11) && $urandom_range(0, 1) == 1) s.din = $urandom_range(0, 20);
      s.vpc  = $urandom;
      s.bd   = 1'($urandom_range(0, 1));
      s.code = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      s.hw   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      s.clr  = ($urandom_range(0, 3) == 0);
      go(s);
    end

    // reset in the middle of a handler
    s = idle(); s.en = 1; s.add = 12; s.din = 32'h0; go(s);
    s = idle(); s.code = 3; s.vpc = 32'h5000; go(s);
    do_reset(1);
    s = idle(); s.add = 12; go(s, 1, 32'd0);
    s = idle(); s.add = 14; go(s, 1, 32'd0);

    repeat (3) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
